// File: rtl/ecc_read_sequencer.sv
// ecc_read_sequencer: sequences one ECC-protected read through the
// ADC input buffer, LLR settle window and NB-LDPC decoder handshake.
module ecc_read_sequencer #(
    parameter int PERIOD      = 32,
    parameter int COUNTER_BIT = 5,
    parameter int SETTLE_CYC  = 1,
    parameter int TIMEOUT_CYC = 1023,
    parameter int TO_BIT      = 10
) (
    input  logic                   ADC_CLK,
    input  logic                   SYS_RST,
    input  logic                   START,
    input  logic                   CIM_MODE,
    input  logic                   ADC_VALID,
    input  logic                   ACK,
    input  logic                   DEC_DONE,
    input  logic                   DEC_SUCCESS,
    output logic                   CE,
    output logic                   CIM_E,
    output logic [COUNTER_BIT-1:0] ROW_ADDR,
    output logic                   DEC_START,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR,
    output logic                   TIMEOUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SETTLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [COUNTER_BIT-1:0] LP_ROW_LAST    = COUNTER_BIT'(PERIOD - 1);
    localparam logic [3:0]             LP_SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [TO_BIT-1:0]      LP_TO_LIMIT    = TO_BIT'(TIMEOUT_CYC);

    state_t                 r_state,  w_next;
    logic [COUNTER_BIT-1:0] r_row,    w_row_next;
    logic [3:0]             r_settle, w_settle_next;
    logic [TO_BIT-1:0]      r_to,     w_to_next;
    logic [TO_BIT-1:0]      w_to_inc;
    logic                   r_cim,    w_cim_next;
    logic                   r_err,    w_err_next;
    logic                   r_tout,   w_tout_next;

    assign w_to_inc = r_to + TO_BIT'(1);

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge ADC_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_settle <= '0;
            r_to     <= '0;
            r_cim    <= 1'b0;
            r_err    <= 1'b0;
            r_tout   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_row    <= w_row_next;
            r_settle <= w_settle_next;
            r_to     <= w_to_next;
            r_cim    <= w_cim_next;
            r_err    <= w_err_next;
            r_tout   <= w_tout_next;
        end
    end

    // Next-state and counter updates; decoder completion beats the timeout
    always_comb begin
        w_next        = r_state;
        w_row_next    = r_row;
        w_settle_next = r_settle;
        w_to_next     = r_to;
        w_cim_next    = r_cim;
        w_err_next    = r_err;
        w_tout_next   = r_tout;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next     = S_FILL;
                    w_cim_next = CIM_MODE;
                    w_row_next = '0;
                end
            end
            S_FILL: begin
                if (ADC_VALID) begin
                    if (r_row == LP_ROW_LAST) begin
                        w_next        = S_SETTLE;
                        w_row_next    = '0;
                        w_settle_next = '0;
                    end else begin
                        w_row_next = r_row + COUNTER_BIT'(1);
                    end
                end
            end
            S_SETTLE: begin
                if (r_settle == LP_SETTLE_LAST) begin
                    w_next        = S_LAUNCH;
                    w_settle_next = '0;
                end else begin
                    w_settle_next = r_settle + 4'd1;
                end
            end
            S_LAUNCH: begin
                w_to_next = '0;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                w_to_next = w_to_inc;
                if (DEC_DONE) begin
                    w_next      = S_DONE;
                    w_err_next  = ~DEC_SUCCESS;
                    w_tout_next = 1'b0;
                end else if (w_to_inc == LP_TO_LIMIT) begin
                    w_next      = S_DONE;
                    w_err_next  = 1'b1;
                    w_tout_next = 1'b1;
                end
            end
            S_DONE: begin
                if (ACK) begin
                    w_next      = S_IDLE;
                    w_err_next  = 1'b0;
                    w_tout_next = 1'b0;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign CE        = (r_state == S_FILL) && ADC_VALID;
    assign CIM_E     = r_cim;
    assign ROW_ADDR  = r_row;
    assign DEC_START = (r_state == S_LAUNCH);
    assign BUSY      = (r_state != S_IDLE);
    assign DONE      = (r_state == S_DONE);
    assign ERR       = r_err;
    assign TIMEOUT   = r_tout;

endmodule

// File: tb/tb_ecc_read_sequencer.sv
// tb_ecc_read_sequencer: directed bench for the ECC read sequencer,
// built with a short timeout so the timeout paths are reachable.
module tb_ecc_read_sequencer;

    logic       ADC_CLK;
    logic       SYS_RST;
    logic       START;
    logic       CIM_MODE;
    logic       ADC_VALID;
    logic       ACK;
    logic       DEC_DONE;
    logic       DEC_SUCCESS;
    logic       CE;
    logic       CIM_E;
    logic [4:0] ROW_ADDR;
    logic       DEC_START;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic       TIMEOUT;

    int n_checks = 0;
    int n_errors = 0;

    ecc_read_sequencer #(
        .PERIOD      (32),
        .COUNTER_BIT (5),
        .SETTLE_CYC  (1),
        .TIMEOUT_CYC (15),
        .TO_BIT      (4)
    ) dut (
        .ADC_CLK     (ADC_CLK),
        .SYS_RST     (SYS_RST),
        .START       (START),
        .CIM_MODE    (CIM_MODE),
        .ADC_VALID   (ADC_VALID),
        .ACK         (ACK),
        .DEC_DONE    (DEC_DONE),
        .DEC_SUCCESS (DEC_SUCCESS),
        .CE          (CE),
        .CIM_E       (CIM_E),
        .ROW_ADDR    (ROW_ADDR),
        .DEC_START   (DEC_START),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ERR         (ERR),
        .TIMEOUT     (TIMEOUT)
    );

    initial ADC_CLK = 1'b0;
    always #5 ADC_CLK = ~ADC_CLK;

    task automatic tick();
        @(posedge ADC_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full-speed fill; returns in the LAUNCH cycle
    task automatic go_launch(input logic mode);
        int cyc;
        int ces;
        START = 1'b1;
        CIM_MODE = mode;
        ADC_VALID = 1'b1;
        tick();
        START = 1'b0;
        cyc = 0;
        ces = 0;
        while (DEC_START !== 1'b1 && cyc < 100) begin
            if (CE === 1'b1) ces++;
            tick();
            cyc++;
        end
        chk("launch_latency", cyc, 33);
        chk("ce_beats", ces, 32);
        chk("launch_cim_e", CIM_E, mode);
        ADC_VALID = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ces;
        int launch_c;
        int cyc;

        SYS_RST = 1'b1;
        START = 1'b0;
        CIM_MODE = 1'b0;
        ADC_VALID = 1'b0;
        ACK = 1'b0;
        DEC_DONE = 1'b0;
        DEC_SUCCESS = 1'b0;
        tick();
        tick();
        chk("rst_ce", CE, 0);
        chk("rst_cim_e", CIM_E, 0);
        chk("rst_row", ROW_ADDR, 0);
        chk("rst_dec_start", DEC_START, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_timeout", TIMEOUT, 0);
        SYS_RST = 1'b0;
        tick();

        // Nominal CIM read, ADC_VALID tied high
        START = 1'b1;
        CIM_MODE = 1'b1;
        ADC_VALID = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("nom_row", ROW_ADDR, i);
            chk("nom_ce", CE, 1);
            chk("nom_dec_start_low", DEC_START, 0);
            tick();
        end
        chk("nom_settle_ce", CE, 0);
        chk("nom_settle_row", ROW_ADDR, 0);
        chk("nom_settle_dec_start", DEC_START, 0);
        tick();
        chk("nom_dec_start_c34", DEC_START, 1);
        chk("nom_cim_e", CIM_E, 1);
        ADC_VALID = 1'b0;
        tick();
        chk("nom_dec_start_pulse", DEC_START, 0);
        chk("nom_wait_busy", BUSY, 1);
        DEC_DONE = 1'b1;
        DEC_SUCCESS = 1'b1;
        tick();
        DEC_DONE = 1'b0;
        chk("nom_done", DONE, 1);
        chk("nom_err", ERR, 0);
        chk("nom_timeout", TIMEOUT, 0);
        tick();
        chk("nom_done_held", DONE, 1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("nom_ack_done", DONE, 0);
        chk("nom_ack_busy", BUSY, 0);

        // Stalled SA fill: ADC_VALID toggles starting high
        START = 1'b1;
        CIM_MODE = 1'b0;
        tick();
        START = 1'b0;
        ces = 0;
        launch_c = -1;
        for (int c = 0; c < 66; c++) begin
            ADC_VALID = (c % 2 == 0);
            #1;
            if (CE === 1'b1) ces++;
            if (c < 63) chk("stall_row", ROW_ADDR, (c + 1) / 2);
            if (DEC_START === 1'b1 && launch_c < 0) launch_c = c;
            tick();
        end
        ADC_VALID = 1'b0;
        chk("stall_ce_count", ces, 32);
        chk("stall_launch", launch_c, 64);
        chk("stall_cim_e", CIM_E, 0);

        // Decode failure, then ACK+START together
        DEC_DONE = 1'b1;
        DEC_SUCCESS = 1'b0;
        tick();
        DEC_DONE = 1'b0;
        chk("fail_done", DONE, 1);
        chk("fail_err", ERR, 1);
        chk("fail_timeout", TIMEOUT, 0);
        ACK = 1'b1;
        START = 1'b1;
        tick();
        ACK = 1'b0;
        START = 1'b0;
        chk("ackstart_busy", BUSY, 0);
        chk("ackstart_err", ERR, 0);
        tick();
        chk("ackstart_stay_idle", BUSY, 0);

        // DEC_DONE in IDLE is ignored
        DEC_DONE = 1'b1;
        DEC_SUCCESS = 1'b0;
        tick();
        DEC_DONE = 1'b0;
        chk("idle_decdone_done", DONE, 0);
        chk("idle_decdone_err", ERR, 0);

        // Timeout: DONE appears 16 cycles after the LAUNCH cycle
        go_launch(1'b1);
        for (int j = 1; j < 16; j++) begin
            tick();
            chk("to_not_done", DONE, 0);
        end
        tick();
        chk("to_done", DONE, 1);
        chk("to_err", ERR, 1);
        chk("to_timeout", TIMEOUT, 1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("to_ack_timeout", TIMEOUT, 0);

        // DEC_DONE on the timeout cycle wins
        go_launch(1'b0);
        for (int j = 1; j < 15; j++) tick();
        tick();
        DEC_DONE = 1'b1;
        DEC_SUCCESS = 1'b1;
        tick();
        DEC_DONE = 1'b0;
        chk("tie_done", DONE, 1);
        chk("tie_err", ERR, 0);
        chk("tie_timeout", TIMEOUT, 0);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;

        // START / CIM_MODE ignored during FILL and WAIT
        START = 1'b1;
        CIM_MODE = 1'b1;
        ADC_VALID = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("ign_row5", ROW_ADDR, 5);
        START = 1'b1;
        CIM_MODE = 1'b0;
        tick();
        START = 1'b0;
        chk("ign_row6", ROW_ADDR, 6);
        chk("ign_cim_fill", CIM_E, 1);
        cyc = 0;
        while (DEC_START !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("ign_launch_wait", cyc, 27);
        ADC_VALID = 1'b0;
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("ign_wait_busy", BUSY, 1);
        chk("ign_wait_row", ROW_ADDR, 0);
        chk("ign_wait_cim", CIM_E, 1);
        chk("ign_wait_dec_start", DEC_START, 0);

        // Async reset in WAIT, between clock edges
        #2;
        SYS_RST = 1'b1;
        #1;
        chk("arst_wait_busy", BUSY, 0);
        chk("arst_wait_cim", CIM_E, 0);
        chk("arst_wait_done", DONE, 0);
        SYS_RST = 1'b0;
        tick();

        // Async reset at ROW_ADDR=17, then a clean fill
        START = 1'b1;
        CIM_MODE = 1'b1;
        ADC_VALID = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("arst_row17", ROW_ADDR, 17);
        chk("arst_ce_before", CE, 1);
        #2;
        SYS_RST = 1'b1;
        #1;
        chk("arst_fill_row", ROW_ADDR, 0);
        chk("arst_fill_ce", CE, 0);
        chk("arst_fill_busy", BUSY, 0);
        chk("arst_fill_cim", CIM_E, 0);
        ADC_VALID = 1'b0;
        tick();
        SYS_RST = 1'b0;
        tick();
        go_launch(1'b1);
        tick();
        DEC_DONE = 1'b1;
        DEC_SUCCESS = 1'b1;
        tick();
        DEC_DONE = 1'b0;
        chk("post_rst_done", DONE, 1);
        chk("post_rst_err", ERR, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
